// File: rtl/alu_ctrl_pkg.sv
// Shared constants, encodings and decode payload for the multi-cycle ALU control block.
package alu_ctrl_pkg;

  localparam int unsigned CODE_W = 5;

  localparam logic [CODE_W-1:0] C_AND   = 5'b00000;
  localparam logic [CODE_W-1:0] C_OR    = 5'b00001;
  localparam logic [CODE_W-1:0] C_ADD   = 5'b00010;
  localparam logic [CODE_W-1:0] C_BEQ   = 5'b00011;
  localparam logic [CODE_W-1:0] C_MUL   = 5'b00100;
  localparam logic [CODE_W-1:0] C_SLTIU = 5'b00101;
  localparam logic [CODE_W-1:0] C_SUB   = 5'b00110;
  localparam logic [CODE_W-1:0] C_SLT   = 5'b00111;
  localparam logic [CODE_W-1:0] C_LW    = 5'b01000;
  localparam logic [CODE_W-1:0] C_BNE   = 5'b01001;
  localparam logic [CODE_W-1:0] C_LUI   = 5'b01011;
  localparam logic [CODE_W-1:0] C_SLL   = 5'b01101;
  localparam logic [CODE_W-1:0] C_SRA   = 5'b01110;
  localparam logic [CODE_W-1:0] C_SRAV  = 5'b01111;
  localparam logic [CODE_W-1:0] C_MULTU = 5'b10000;
  localparam logic [CODE_W-1:0] C_DIV   = 5'b10001;
  localparam logic [CODE_W-1:0] C_DIVU  = 5'b10010;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MUL   = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_SLTIU = 3'b010;
  localparam logic [2:0] OP_LUI   = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_LW    = 3'b101;
  localparam logic [2:0] OP_BNE   = 3'b110;
  localparam logic [2:0] OP_ORI   = 3'b111;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] ctrl;
    logic              jr;
    logic              is_mdu;
    mdu_op_t           mdu_op;
    logic              illegal;
  } dec_t;

  // ALU control code reported when an MDU op completes.
  function automatic logic [CODE_W-1:0] mdu_code(input mdu_op_t op);
    case (op)
      MDU_MUL:   mdu_code = C_MUL;
      MDU_MULTU: mdu_code = C_MULTU;
      MDU_DIV:   mdu_code = C_DIV;
      default:   mdu_code = C_DIVU;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational funct/ALUOp decode into control code, jr flag, MDU class and illegal flag.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic [FUNCT_W-1:0] funct,
  input  logic [ALUOP_W-1:0] aluop,
  output dec_t               dec
);

  always_comb begin
    dec = '0;
    case (aluop)
      ALUOP_W'(OP_ADDI):  dec.ctrl = C_ADD;
      ALUOP_W'(OP_SLTIU): dec.ctrl = C_SLTIU;
      ALUOP_W'(OP_LUI):   dec.ctrl = C_LUI;
      ALUOP_W'(OP_BEQ):   dec.ctrl = C_BEQ;
      ALUOP_W'(OP_LW):    dec.ctrl = C_LW;
      ALUOP_W'(OP_BNE):   dec.ctrl = C_BNE;
      ALUOP_W'(OP_ORI):   dec.ctrl = C_OR;
      ALUOP_W'(OP_RTYPE): begin
        case (funct)
          FUNCT_W'(F_ADDU): dec.ctrl = C_ADD;
          FUNCT_W'(F_SUBU): dec.ctrl = C_SUB;
          FUNCT_W'(F_AND):  dec.ctrl = C_AND;
          FUNCT_W'(F_OR):   dec.ctrl = C_OR;
          FUNCT_W'(F_SLT):  dec.ctrl = C_SLT;
          FUNCT_W'(F_SRA):  dec.ctrl = C_SRA;
          FUNCT_W'(F_SRAV): dec.ctrl = C_SRAV;
          FUNCT_W'(F_SLL):  dec.ctrl = C_SLL;
          FUNCT_W'(F_JR): begin
            dec.ctrl = C_ADD;
            dec.jr   = 1'b1;
          end
          FUNCT_W'(F_MUL): begin
            dec.ctrl   = C_MUL;
            dec.is_mdu = 1'b1;
            dec.mdu_op = MDU_MUL;
          end
          FUNCT_W'(F_MULTU): begin
            dec.ctrl   = C_MULTU;
            dec.is_mdu = 1'b1;
            dec.mdu_op = MDU_MULTU;
          end
          FUNCT_W'(F_DIV): begin
            dec.ctrl   = C_DIV;
            dec.is_mdu = 1'b1;
            dec.mdu_op = MDU_DIV;
          end
          FUNCT_W'(F_DIVU): begin
            dec.ctrl   = C_DIVU;
            dec.is_mdu = 1'b1;
            dec.mdu_op = MDU_DIVU;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_mc.sv
// Multi-cycle ALU control: registered decode with handshake, MDU sequencing, stall and flush.
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CTRL_W  = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic               flush_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               ctrl_valid_o,
  output logic               jr_o,
  output logic               illegal_o,
  output logic               mdu_start_o,
  output logic [1:0]         mdu_op_o,
  output logic               mdu_abort_o,
  output logic               stall_o
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  dec_t              dec;
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  mdu_op_t           op_q, op_nxt;
  logic [CTRL_W-1:0] ctrl_nxt;
  logic              jr_nxt, cv_nxt, ill_nxt, start_nxt, abort_nxt;

  alu_ctrl_dec #(
    .FUNCT_W (FUNCT_W),
    .ALUOP_W (ALUOP_W)
  ) u_dec (
    .funct (funct_i),
    .aluop (ALUOp_i),
    .dec   (dec)
  );

  assign ready_o  = (state == IDLE);
  assign stall_o  = (state == RUN);
  assign mdu_op_o = op_q;

  // Next-state and output decode; pulses default low, control word holds.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    ctrl_nxt  = ALUCtrl_o;
    jr_nxt    = jr_o;
    cv_nxt    = 1'b0;
    ill_nxt   = 1'b0;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i && !flush_i) begin
          if (dec.illegal) begin
            ill_nxt = 1'b1;
          end else if (dec.is_mdu) begin
            start_nxt = 1'b1;
            op_nxt    = dec.mdu_op;
            state_nxt = RUN;
            cnt_nxt   = dec.mdu_op[1] ? DIV_CNT : MUL_CNT;
          end else begin
            cv_nxt   = 1'b1;
            ctrl_nxt = CTRL_W'(dec.ctrl);
            jr_nxt   = dec.jr;
          end
        end
      end
      RUN: begin
        // Flush wins over completion, even on the final count.
        if (flush_i) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
          cv_nxt    = 1'b1;
          ctrl_nxt  = CTRL_W'(mdu_code(op_q));
          jr_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= MDU_MUL;
      ALUCtrl_o    <= '0;
      jr_o         <= 1'b0;
      ctrl_valid_o <= 1'b0;
      illegal_o    <= 1'b0;
      mdu_start_o  <= 1'b0;
      mdu_abort_o  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      op_q         <= op_nxt;
      ALUCtrl_o    <= ctrl_nxt;
      jr_o         <= jr_nxt;
      ctrl_valid_o <= cv_nxt;
      illegal_o    <= ill_nxt;
      mdu_start_o  <= start_nxt;
      mdu_abort_o  <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Scoreboard bench for alu_ctrl_mc: expected pulses queued at drive time, matched on output.
module tb_alu_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst, valid, flush;
  logic [5:0] funct;
  logic [2:0] aluop;

  logic       ready, cv, jr, il, st, ab, stall;
  logic [4:0] ctrl;
  logic [1:0] op;

  logic       d1_ready, d1_cv, d1_jr, d1_il, d1_st, d1_ab, d1_stall;
  logic [4:0] d1_ctrl;
  logic [1:0] d1_op;

  alu_ctrl_mc dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
    .funct_i(funct), .ALUOp_i(aluop), .flush_i(flush),
    .ALUCtrl_o(ctrl), .ctrl_valid_o(cv), .jr_o(jr), .illegal_o(il),
    .mdu_start_o(st), .mdu_op_o(op), .mdu_abort_o(ab), .stall_o(stall)
  );

  alu_ctrl_mc #(.MUL_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(d1_ready),
    .funct_i(funct), .ALUOp_i(aluop), .flush_i(flush),
    .ALUCtrl_o(d1_ctrl), .ctrl_valid_o(d1_cv), .jr_o(d1_jr), .illegal_o(d1_il),
    .mdu_start_o(d1_st), .mdu_op_o(d1_op), .mdu_abort_o(d1_ab), .stall_o(d1_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // kind: 0 ctrl_valid, 1 illegal, 2 mdu_start, 3 mdu_abort
  typedef struct {
    int         kind;
    logic [4:0] ctrl;
    logic       jr;
    logic [1:0] op;
    int         at;
  } ev_t;

  ev_t        sb[$];
  logic [4:0] m_ctrl;
  logic       m_jr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference decode taken from the code tables.
  task automatic ref_dec(input logic [2:0] a, input logic [5:0] f,
                         output logic [4:0] c, output logic j, output logic m,
                         output logic [1:0] o, output logic ill);
    c = 5'b00000; j = 1'b0; m = 1'b0; o = 2'b00; ill = 1'b0;
    case (a)
      3'b001: c = 5'b00010;
      3'b010: c = 5'b00101;
      3'b011: c = 5'b01011;
      3'b100: c = 5'b00011;
      3'b101: c = 5'b01000;
      3'b110: c = 5'b01001;
      3'b111: c = 5'b00001;
      default: begin
        case (f)
          6'b100001: c = 5'b00010;
          6'b100011: c = 5'b00110;
          6'b100100: c = 5'b00000;
          6'b100101: c = 5'b00001;
          6'b101010: c = 5'b00111;
          6'b000011: c = 5'b01110;
          6'b000111: c = 5'b01111;
          6'b000000: c = 5'b01101;
          6'b001000: begin c = 5'b00010; j = 1'b1; end
          6'b011000: begin c = 5'b00100; m = 1'b1; o = 2'b00; end
          6'b011001: begin c = 5'b10000; m = 1'b1; o = 2'b01; end
          6'b011010: begin c = 5'b10001; m = 1'b1; o = 2'b10; end
          6'b011011: begin c = 5'b10010; m = 1'b1; o = 2'b11; end
          default:   ill = 1'b1;
        endcase
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle and queue the pulses it should produce.
  task automatic issue(input logic [2:0] a, input logic [5:0] f, input bit will_flush);
    logic [4:0] c;
    logic       j, m, ill;
    logic [1:0] o;
    int         lat;
    ev_t        e;
    ref_dec(a, f, c, j, m, o, ill);
    valid = 1'b1; aluop = a; funct = f;
    if (ill) begin
      e = '{1, m_ctrl, m_jr, 2'b00, cyc + 1};
      sb.push_back(e);
    end else if (m) begin
      lat = o[1] ? 32 : 4;
      e = '{2, 5'b0, 1'b0, o, cyc + 1};
      sb.push_back(e);
      if (!will_flush) begin
        e = '{0, c, 1'b0, o, cyc + 1 + lat};
        sb.push_back(e);
        m_ctrl = c; m_jr = 1'b0;
      end
    end else begin
      e = '{0, c, j, 2'b00, cyc + 1};
      sb.push_back(e);
      m_ctrl = c; m_jr = j;
    end
    step();
    valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      step();
      k++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  int  mon_n, mon_kind;
  ev_t mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      mon_n = 32'(cv) + 32'(il) + 32'(st) + 32'(ab);
      if (mon_n > 1) check("exclusive", 32'(mon_n), 32'd1);
      if (mon_n != 0) begin
        mon_kind = cv ? 0 : il ? 1 : st ? 2 : 3;
        if (sb.size() == 0) begin
          check("unexpected_pulse_kind", 32'(mon_kind), 32'hff);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_kind", 32'(mon_kind), 32'(mon_e.kind));
          check("pulse_cycle", 32'(cyc), 32'(mon_e.at));
          case (mon_e.kind)
            0: begin
              check("ctrl", 32'(ctrl), 32'(mon_e.ctrl));
              check("jr", 32'(jr), 32'(mon_e.jr));
            end
            1: begin
              check("illegal_ctrl_hold", 32'(ctrl), 32'(mon_e.ctrl));
              check("illegal_jr_hold", 32'(jr), 32'(mon_e.jr));
            end
            2: check("mdu_op", 32'(op), 32'(mon_e.op));
            default: check("abort_ctrl_hold", 32'(ctrl), 32'(mon_e.ctrl));
          endcase
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  logic [5:0] rfun [13] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010,
                            6'b000011, 6'b000111, 6'b000000, 6'b001000,
                            6'b011000, 6'b011001, 6'b011010, 6'b011011};

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_ready"}, 32'(ready), 32'd1);
    check({pfx, "_stall"}, 32'(stall), 32'd0);
    check({pfx, "_ctrl"}, 32'(ctrl), 32'd0);
    check({pfx, "_cv"}, 32'(cv), 32'd0);
    check({pfx, "_jr"}, 32'(jr), 32'd0);
    check({pfx, "_illegal"}, 32'(il), 32'd0);
    check({pfx, "_start"}, 32'(st), 32'd0);
    check({pfx, "_op"}, 32'(op), 32'd0);
    check({pfx, "_abort"}, 32'(ab), 32'd0);
  endtask

  initial begin
    int t0;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; funct = '0; aluop = '0;
    m_ctrl = '0; m_jr = 1'b0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_d1_ready", 32'(d1_ready), 32'd1);
    step();

    // Back-to-back single-cycle ops: subu then jr.
    issue(3'b000, 6'b100011, 1'b0);
    issue(3'b000, 6'b001000, 1'b0);
    drain(5);

    // mul with a valid presented while busy; MUL_LAT=1 instance checked alongside.
    t0 = cyc;
    issue(3'b000, 6'b011000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("mul_ready_low", 32'(ready), 32'd0);
      check("mul_stall_high", 32'(stall), 32'd1);
      if (i == 1) begin
        check("lat1_start", 32'(d1_st), 32'd1);
        check("lat1_ready_low", 32'(d1_ready), 32'd0);
      end
      if (i == 2) begin
        check("lat1_cv", 32'(d1_cv), 32'd1);
        check("lat1_ctrl", 32'(d1_ctrl), 32'h04);
        check("lat1_ready", 32'(d1_ready), 32'd1);
        valid = 1'b1; aluop = 3'b000; funct = 6'b100001;
      end
      if (i == 3) valid = 1'b0;
    end
    @(negedge clk);
    check("mul_ready_back", 32'(ready), 32'd1);
    check("mul_done_cycle", 32'(cyc), 32'(t0 + 5));
    step();
    drain(5);
    repeat (4) step();

    // divu flushed mid-run.
    t0 = cyc;
    issue(3'b000, 6'b011011, 1'b1);
    while (cyc < t0 + 10) step();
    flush = 1'b1;
    sb.push_back('{3, m_ctrl, m_jr, 2'b00, t0 + 11});
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready", 32'(ready), 32'd1);
    step();
    repeat (40) step();
    check("flush_queue_empty", 32'(sb.size()), 32'd0);

    // mul flushed on its final count cycle.
    t0 = cyc;
    issue(3'b000, 6'b011000, 1'b1);
    while (cyc < t0 + 4) step();
    flush = 1'b1;
    sb.push_back('{3, m_ctrl, m_jr, 2'b00, t0 + 5});
    step();
    flush = 1'b0;
    repeat (8) step();
    check("flush_last_queue_empty", 32'(sb.size()), 32'd0);

    // Flush in IDLE drops the instruction.
    valid = 1'b1; flush = 1'b1; aluop = 3'b001; funct = 6'b000000;
    step();
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_cv", 32'(cv), 32'd0);
    check("flush_idle_ready", 32'(ready), 32'd1);
    step();

    // Illegal funct keeps the previous control word.
    issue(3'b000, 6'b111111, 1'b0);
    drain(4);

    // Sweep of non-R ALUOp classes (funct ignored) and every R-type funct.
    for (int a = 1; a < 8; a++) issue(3'(a), 6'b111111, 1'b0);
    drain(10);
    for (int i = 0; i < 13; i++) begin
      issue(3'b000, rfun[i], 1'b0);
      drain(40);
      repeat (3) step();
    end

    // Reset held two cycles mid-run: silent abort.
    issue(3'b000, 6'b011010, 1'b1);
    repeat (3) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    m_ctrl = '0; m_jr = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrun_reset");
    step();
    repeat (40) step();
    check("midrun_reset_queue", 32'(sb.size()), 32'd0);
    issue(3'b000, 6'b100101, 1'b0);
    drain(5);

    check("final_queue", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
